spi_fifo_seq: RTL and testbench

- CPU-mapped SPI transfer sequencer that sits upstream of the SPI shift core.
- Buffers CPU bytes in a TX FIFO and hands them to the core one at a time: enable pulse, wait for busy to rise, wait for busy to fall.
- Pushes each received byte into an RX FIFO.
- Lets firmware queue bursts without polling busy per byte.

---
 rtl/spi_fifo_seq_if.sv | 24 ++
 rtl/spi_fifo_seq.sv | 168 ++++++++++++++++
 tb/tb_spi_fifo_seq.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_fifo_seq_if.sv
// CPU register bus and SPI shift-core handshake seen by spi_fifo_seq.
// The master side is the environment: the CPU plus the downstream shift core.
interface spi_fifo_seq_if;
   logic [7:0] addr;
   logic [7:0] dout;
   logic [7:0] din;
   logic       wr_en;
   logic       rd_en;
   logic       core_enable;
   logic [7:0] core_tx_data;
   logic       core_busy;
   logic [7:0] core_rx_data;
   logic       irq;

   modport master (
      output addr, dout, wr_en, rd_en, core_busy, core_rx_data,
      input  din, core_enable, core_tx_data, irq
   );

   modport slave (
      input  addr, dout, wr_en, rd_en, core_busy, core_rx_data,
      output din, core_enable, core_tx_data, irq
   );
endinterface

// File: rtl/spi_fifo_seq.sv
// CPU-mapped SPI transfer sequencer: TX/RX byte FIFOs feeding an SPI shift core.
// Optional level interrupt enabled by defining SPI_FIFO_SEQ_IRQ_EN.
module spi_fifo_seq #(
   parameter logic [7:0] BASE_ADDR  = 8'h84,
   parameter logic [7:0] LAST_ADDR  = 8'h87,
   parameter int         DEPTH_LOG2 = 2
) (
   input logic           clk,
   input logic           reset_n,
   spi_fifo_seq_if.slave bus
);
   localparam int                    DEPTH    = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = (DEPTH_LOG2)'(1);

   typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE, CAPTURE} state_t;

   state_t                state_q;
   logic                  core_enable_q;
   logic [7:0]            core_tx_data_q;
   logic [7:0]            tx_mem_q [DEPTH];
   logic [7:0]            rx_mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
   logic [DEPTH_LOG2:0]   tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
   logic                  en_q, err_q, err_d;
   logic [7:0]            din_q, din_d;
   logic                  irq_en, irq_q;

   logic in_win, wr_ctrl, wr_tx, rd_rx, busy;
   logic tx_empty, tx_full, rx_empty, rx_full;
   logic tx_push, tx_pop, rx_push, rx_pop;

   // LEVEL nibbles saturate so a full 16-entry FIFO never reads as 0.
   function automatic logic [3:0] sat_level(input logic [DEPTH_LOG2:0] cnt);
      logic [4:0] ext;
      ext = 5'(cnt);
      return (ext > 5'd15) ? 4'hF : ext[3:0];
   endfunction

   assign in_win   = (bus.addr >= BASE_ADDR) && (bus.addr <= LAST_ADDR);
   assign wr_ctrl  = bus.wr_en && in_win && (bus.addr[1:0] == 2'd0);
   assign wr_tx    = bus.wr_en && in_win && (bus.addr[1:0] == 2'd1);
   assign rd_rx    = bus.rd_en && in_win && (bus.addr[1:0] == 2'd2);
   assign busy     = (state_q != IDLE);
   assign tx_empty = (tx_cnt_q == '0);
   assign tx_full  = (tx_cnt_q == FULL_CNT);
   assign rx_empty = (rx_cnt_q == '0);
   assign rx_full  = (rx_cnt_q == FULL_CNT);

   // RX is never full during a transfer: a byte only starts when RX has room.
   assign tx_pop   = (state_q == IDLE) && en_q && !tx_empty && !rx_full;
   assign tx_push  = wr_tx && !tx_full;
   assign rx_push  = (state_q == CAPTURE);
   assign rx_pop   = rd_rx && !rx_empty;

   always_comb begin
      tx_cnt_d = tx_cnt_q;
      if (tx_push && !tx_pop)      tx_cnt_d = tx_cnt_q + CNT_ONE;
      else if (tx_pop && !tx_push) tx_cnt_d = tx_cnt_q - CNT_ONE;

      rx_cnt_d = rx_cnt_q;
      if (rx_push && !rx_pop)      rx_cnt_d = rx_cnt_q + CNT_ONE;
      else if (rx_pop && !rx_push) rx_cnt_d = rx_cnt_q - CNT_ONE;

      // A new error in the same cycle as a clear request keeps ERR set.
      err_d = err_q;
      if (wr_ctrl && bus.dout[7])                     err_d = 1'b0;
      if ((wr_tx && tx_full) || (rd_rx && rx_empty))  err_d = 1'b1;

      din_d = din_q;
      if (bus.rd_en && in_win) begin
         case (bus.addr[1:0])
            2'd0:    din_d = {err_q, rx_full, rx_empty, tx_full, tx_empty, busy, irq_en, en_q};
            2'd1:    din_d = 8'h00;
            2'd2:    din_d = rx_empty ? 8'h00 : rx_mem_q[rx_rd_q];
            default: din_d = {sat_level(tx_cnt_q), sat_level(rx_cnt_q)};
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            tx_mem_q[i] <= '0;
            rx_mem_q[i] <= '0;
         end
         tx_wr_q  <= '0;
         tx_rd_q  <= '0;
         rx_wr_q  <= '0;
         rx_rd_q  <= '0;
         tx_cnt_q <= '0;
         rx_cnt_q <= '0;
         en_q     <= 1'b0;
         err_q    <= 1'b0;
         din_q    <= '0;
      end else begin
         if (tx_push) begin
            tx_mem_q[tx_wr_q] <= bus.dout;
            tx_wr_q           <= tx_wr_q + PTR_ONE;
         end
         if (tx_pop) tx_rd_q <= tx_rd_q + PTR_ONE;
         if (rx_push) begin
            rx_mem_q[rx_wr_q] <= bus.core_rx_data;
            rx_wr_q           <= rx_wr_q + PTR_ONE;
         end
         if (rx_pop) rx_rd_q <= rx_rd_q + PTR_ONE;
         tx_cnt_q <= tx_cnt_d;
         rx_cnt_q <= rx_cnt_d;
         if (wr_ctrl) en_q <= bus.dout[0];
         err_q <= err_d;
         din_q <= din_d;
      end
   end

   // Transfer handshake: enable until busy rises, then wait for busy to fall.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= IDLE;
         core_enable_q  <= 1'b0;
         core_tx_data_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (tx_pop) begin
                  core_tx_data_q <= tx_mem_q[tx_rd_q];
                  core_enable_q  <= 1'b1;
                  state_q        <= WAIT_BUSY;
               end
            end
            WAIT_BUSY: begin
               if (bus.core_busy) begin
                  core_enable_q <= 1'b0;
                  state_q       <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               if (!bus.core_busy) state_q <= CAPTURE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef SPI_FIFO_SEQ_IRQ_EN
   logic irq_en_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_en_q <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         if (wr_ctrl) irq_en_q <= bus.dout[1];
         irq_q <= irq_en_q & ((!busy & tx_empty & !rx_empty) | err_q);
      end
   end

   assign irq_en = irq_en_q;
`else
   assign irq_en = 1'b0;
   assign irq_q  = 1'b0;
`endif

   assign bus.din          = in_win ? din_q : 8'hzz;
   assign bus.core_enable  = core_enable_q;
   assign bus.core_tx_data = core_tx_data_q;
   assign bus.irq          = irq_q;
endmodule

// File: tb/tb_spi_fifo_seq.sv
// Directed bench for spi_fifo_seq with a loopback SPI core model (10 busy cycles per byte).
`timescale 1ns/1ps
module tb_spi_fifo_seq;
   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   int   total   = 0;
   int   bad     = 0;

   spi_fifo_seq_if bus();

   spi_fifo_seq #(
      .BASE_ADDR (8'h84),
      .LAST_ADDR (8'h87),
      .DEPTH_LOG2(2)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   // Loopback core: busy rises the edge after enable is seen, echoes tx byte on fall.
   int         busy_cnt = 0;
   logic [7:0] lat      = 8'h00;
   int         xfer_cnt = 0;
   logic [7:0] xlog [64];
   logic       irq_seen = 1'b0;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.core_busy    <= 1'b0;
         bus.core_rx_data <= 8'h00;
         busy_cnt         <= 0;
      end else if (bus.core_busy) begin
         if (busy_cnt == 1) begin
            bus.core_busy    <= 1'b0;
            bus.core_rx_data <= lat;
         end
         busy_cnt <= busy_cnt - 1;
      end else if (bus.core_enable) begin
         bus.core_busy           <= 1'b1;
         busy_cnt                <= 10;
         lat                     <= bus.core_tx_data;
         xlog[xfer_cnt % 64]     <= bus.core_tx_data;
         xfer_cnt                <= xfer_cnt + 1;
      end
   end

   always @(posedge clk) begin
      if (bus.irq === 1'b1) irq_seen <= 1'b1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
      bus.addr  = a;
      bus.dout  = d;
      bus.wr_en = 1'b1;
      tick();
      bus.wr_en = 1'b0;
   endtask

   task automatic cpu_read(input logic [7:0] a, output logic [7:0] d);
      bus.addr  = a;
      bus.rd_en = 1'b1;
      tick();
      bus.rd_en = 1'b0;
      d = bus.din;
   endtask

   task automatic wait_idle(input int target, output logic ok);
      logic [7:0] s;
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (xfer_cnt >= target) begin ok = 1'b1; break; end
         tick();
      end
      if (ok) begin
         ok = 1'b0;
         for (int i = 0; i < 100; i++) begin
            cpu_read(8'h84, s);
            if (!s[2]) begin ok = 1'b1; break; end
         end
      end
   endtask

   task automatic test_reset();
      logic [7:0] d;
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++; if (bus.core_enable !== 1'b0) begin $display("FAIL rst_enable got=%b exp=0", bus.core_enable); bad++; end
      total++; if (bus.irq !== 1'b0) begin $display("FAIL rst_irq got=%b exp=0", bus.irq); bad++; end
      bus.addr = 8'h84;
      #1;
      total++; if (bus.din !== 8'h00) begin $display("FAIL rst_din_reg got=%h exp=00", bus.din); bad++; end
      reset_n = 1'b1;
      tick();
      cpu_read(8'h84, d);
      total++; if (d !== 8'h28) begin $display("FAIL rst_stat got=%h exp=28", d); bad++; end
      cpu_read(8'h87, d);
      total++; if (d !== 8'h00) begin $display("FAIL rst_level got=%h exp=00", d); bad++; end
      total++; if (bus.core_enable !== 1'b0) begin $display("FAIL rst_enable2 got=%b exp=0", bus.core_enable); bad++; end
   endtask

   task automatic test_single();
      logic [7:0] d;
      logic       ok;
      int         base;
      cpu_write(8'h84, 8'h01);
      base = xfer_cnt;
      cpu_write(8'h85, 8'hA5);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus.core_enable === 1'b1) begin ok = 1'b1; break; end
         tick();
      end
      total++; if (ok !== 1'b1) begin $display("FAIL single_enable_timeout got=%b exp=1", ok); bad++; end
      total++; if (bus.core_tx_data !== 8'hA5) begin $display("FAIL single_txdata got=%h exp=a5", bus.core_tx_data); bad++; end
      tick();
      total++; if ({bus.core_busy, bus.core_enable} !== 2'b11) begin $display("FAIL single_busy_rise got=%b exp=11", {bus.core_busy, bus.core_enable}); bad++; end
      tick();
      total++; if ({bus.core_busy, bus.core_enable} !== 2'b10) begin $display("FAIL single_enable_drop got=%b exp=10", {bus.core_busy, bus.core_enable}); bad++; end
      wait_idle(base + 1, ok);
      total++; if (ok !== 1'b1) begin $display("FAIL single_idle_timeout got=%b exp=1", ok); bad++; end
      total++; if (xlog[base % 64] !== 8'hA5) begin $display("FAIL single_core_byte got=%h exp=a5", xlog[base % 64]); bad++; end
      cpu_read(8'h86, d);
      total++; if (d !== 8'hA5) begin $display("FAIL single_rxdata got=%h exp=a5", d); bad++; end
      cpu_read(8'h87, d);
      total++; if (d !== 8'h00) begin $display("FAIL single_level got=%h exp=00", d); bad++; end
      cpu_read(8'h84, d);
      total++; if (d !== 8'h29) begin $display("FAIL single_stat got=%h exp=29", d); bad++; end
   endtask

   task automatic test_overflow();
      logic [7:0] d;
      logic       ok;
      int         base;
      logic [7:0] vals [5];
      vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      cpu_write(8'h84, 8'h00);
      for (int i = 0; i < 5; i++) cpu_write(8'h85, vals[i]);
      cpu_read(8'h84, d);
      total++; if (d !== 8'hB0) begin $display("FAIL ovf_stat got=%h exp=b0", d); bad++; end
      cpu_read(8'h87, d);
      total++; if (d !== 8'h40) begin $display("FAIL ovf_level got=%h exp=40", d); bad++; end
      cpu_write(8'h84, 8'h80);
      cpu_read(8'h84, d);
      total++; if (d !== 8'h30) begin $display("FAIL ovf_err_clear got=%h exp=30", d); bad++; end
      base = xfer_cnt;
      cpu_write(8'h84, 8'h01);
      wait_idle(base + 4, ok);
      total++; if (ok !== 1'b1) begin $display("FAIL ovf_idle_timeout got=%b exp=1", ok); bad++; end
      repeat (30) tick();
      total++; if (xfer_cnt - base !== 4) begin $display("FAIL ovf_xfer_count got=%0d exp=4", xfer_cnt - base); bad++; end
      for (int i = 0; i < 4; i++) begin
         total++; if (xlog[(base + i) % 64] !== vals[i]) begin $display("FAIL ovf_order%0d got=%h exp=%h", i, xlog[(base + i) % 64], vals[i]); bad++; end
      end
      cpu_read(8'h87, d);
      total++; if (d !== 8'h04) begin $display("FAIL ovf_rx_level got=%h exp=04", d); bad++; end
      cpu_read(8'h84, d);
      total++; if (d !== 8'h49) begin $display("FAIL ovf_rx_full_stat got=%h exp=49", d); bad++; end
      for (int i = 0; i < 4; i++) begin
         cpu_read(8'h86, d);
         total++; if (d !== vals[i]) begin $display("FAIL ovf_rx%0d got=%h exp=%h", i, d, vals[i]); bad++; end
      end
   endtask

   task automatic test_rx_empty();
      logic [7:0] d;
      cpu_read(8'h86, d);
      total++; if (d !== 8'h00) begin $display("FAIL rxe_data got=%h exp=00", d); bad++; end
      cpu_read(8'h84, d);
      total++; if (d !== 8'hA9) begin $display("FAIL rxe_stat got=%h exp=a9", d); bad++; end
      cpu_read(8'h87, d);
      total++; if (d !== 8'h00) begin $display("FAIL rxe_level got=%h exp=00", d); bad++; end
      cpu_write(8'h84, 8'h81);
      cpu_read(8'h84, d);
      total++; if (d !== 8'h29) begin $display("FAIL rxe_clear got=%h exp=29", d); bad++; end
   endtask

   task automatic test_en_clear();
      logic [7:0] d;
      logic       ok;
      int         base;
      cpu_write(8'h84, 8'h00);
      cpu_write(8'h85, 8'hA1);
      cpu_write(8'h85, 8'hA2);
      cpu_write(8'h85, 8'hA3);
      cpu_write(8'h85, 8'hA4);
      base = xfer_cnt;
      cpu_write(8'h84, 8'h01);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (xfer_cnt >= base + 2) begin ok = 1'b1; break; end
         tick();
      end
      total++; if (ok !== 1'b1) begin $display("FAIL enc_second_timeout got=%b exp=1", ok); bad++; end
      cpu_write(8'h84, 8'h00);
      wait_idle(base + 2, ok);
      total++; if (ok !== 1'b1) begin $display("FAIL enc_idle_timeout got=%b exp=1", ok); bad++; end
      repeat (30) tick();
      total++; if (xfer_cnt - base !== 2) begin $display("FAIL enc_xfer_count got=%0d exp=2", xfer_cnt - base); bad++; end
      cpu_read(8'h87, d);
      total++; if (d !== 8'h22) begin $display("FAIL enc_level got=%h exp=22", d); bad++; end
      cpu_read(8'h84, d);
      total++; if (d !== 8'h00) begin $display("FAIL enc_stat got=%h exp=00", d); bad++; end
      cpu_read(8'h86, d);
      total++; if (d !== 8'hA1) begin $display("FAIL enc_rx0 got=%h exp=a1", d); bad++; end
      cpu_read(8'h86, d);
      total++; if (d !== 8'hA2) begin $display("FAIL enc_rx1 got=%h exp=a2", d); bad++; end
      cpu_write(8'h84, 8'h01);
      wait_idle(base + 4, ok);
      total++; if (ok !== 1'b1) begin $display("FAIL enc_drain_timeout got=%b exp=1", ok); bad++; end
      cpu_read(8'h86, d);
      total++; if (d !== 8'hA3) begin $display("FAIL enc_rx2 got=%h exp=a3", d); bad++; end
      cpu_read(8'h86, d);
      total++; if (d !== 8'hA4) begin $display("FAIL enc_rx3 got=%h exp=a4", d); bad++; end
      cpu_read(8'h84, d);
      total++; if (d !== 8'h29) begin $display("FAIL enc_final_stat got=%h exp=29", d); bad++; end
   endtask

   task automatic test_irq();
      logic [7:0] d;
      logic       ok;
      int         base;
`ifdef SPI_FIFO_SEQ_IRQ_EN
      cpu_write(8'h84, 8'h02);
      cpu_read(8'h84, d);
      total++; if (d !== 8'h2A) begin $display("FAIL irq_stat got=%h exp=2a", d); bad++; end
      total++; if (bus.irq !== 1'b0) begin $display("FAIL irq_idle_low got=%b exp=0", bus.irq); bad++; end
      cpu_write(8'h85, 8'hB1);
      cpu_write(8'h85, 8'hB2);
      base = xfer_cnt;
      cpu_write(8'h84, 8'h03);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (xfer_cnt >= base + 2) begin ok = 1'b1; break; end
         tick();
      end
      total++; if (ok !== 1'b1) begin $display("FAIL irq_second_timeout got=%b exp=1", ok); bad++; end
      total++; if (bus.irq !== 1'b0) begin $display("FAIL irq_low_mid got=%b exp=0", bus.irq); bad++; end
      wait_idle(base + 2, ok);
      total++; if (ok !== 1'b1) begin $display("FAIL irq_idle_timeout got=%b exp=1", ok); bad++; end
      tick();
      total++; if (bus.irq !== 1'b1) begin $display("FAIL irq_rise got=%b exp=1", bus.irq); bad++; end
      cpu_read(8'h86, d);
      total++; if (d !== 8'hB1) begin $display("FAIL irq_rx0 got=%h exp=b1", d); bad++; end
      total++; if (bus.irq !== 1'b1) begin $display("FAIL irq_hold got=%b exp=1", bus.irq); bad++; end
      cpu_read(8'h86, d);
      total++; if (d !== 8'hB2) begin $display("FAIL irq_rx1 got=%h exp=b2", d); bad++; end
      tick();
      total++; if (bus.irq !== 1'b0) begin $display("FAIL irq_fall got=%b exp=0", bus.irq); bad++; end
      cpu_write(8'h84, 8'h01);
`else
      cpu_write(8'h84, 8'h03);
      cpu_read(8'h84, d);
      total++; if (d !== 8'h29) begin $display("FAIL irq_en_unstored got=%h exp=29", d); bad++; end
      base = xfer_cnt;
      cpu_write(8'h85, 8'hB1);
      cpu_write(8'h85, 8'hB2);
      wait_idle(base + 2, ok);
      total++; if (ok !== 1'b1) begin $display("FAIL irq_idle_timeout got=%b exp=1", ok); bad++; end
      repeat (3) tick();
      cpu_read(8'h86, d);
      total++; if (d !== 8'hB1) begin $display("FAIL irq_rx0 got=%h exp=b1", d); bad++; end
      cpu_read(8'h86, d);
      total++; if (d !== 8'hB2) begin $display("FAIL irq_rx1 got=%h exp=b2", d); bad++; end
      total++; if (irq_seen !== 1'b0) begin $display("FAIL irq_never got=%b exp=0", irq_seen); bad++; end
      cpu_write(8'h84, 8'h01);
`endif
   endtask

   task automatic test_reset_mid();
      logic [7:0] d;
      logic       ok;
      cpu_write(8'h84, 8'h01);
      cpu_write(8'h85, 8'hC3);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus.core_busy === 1'b1) begin ok = 1'b1; break; end
         tick();
      end
      total++; if (ok !== 1'b1) begin $display("FAIL rmid_busy_timeout got=%b exp=1", ok); bad++; end
      reset_n = 1'b0;
      #1;
      total++; if (bus.core_enable !== 1'b0) begin $display("FAIL rmid_enable got=%b exp=0", bus.core_enable); bad++; end
      total++; if (bus.core_tx_data !== 8'h00) begin $display("FAIL rmid_txdata got=%h exp=00", bus.core_tx_data); bad++; end
      repeat (2) tick();
      reset_n = 1'b1;
      tick();
      cpu_read(8'h84, d);
      total++; if (d !== 8'h28) begin $display("FAIL rmid_stat got=%h exp=28", d); bad++; end
      repeat (20) tick();
      cpu_read(8'h87, d);
      total++; if (d !== 8'h00) begin $display("FAIL rmid_level got=%h exp=00", d); bad++; end
   endtask

   initial begin
      bus.addr  = 8'h00;
      bus.dout  = 8'h00;
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      test_reset();
      test_single();
      test_overflow();
      test_rx_empty();
      test_en_clear();
      test_irq();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
